mips_cpu_regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between NUM_REQ writeback requesters (ALU, load, link/HI-LO).

---
 rtl/mips_cpu_pkg.sv | 19 +
 rtl/mips_cpu_regfile_wb_arbiter_chk.sv | 25 ++
 rtl/mips_cpu_rr_arbiter.sv | 37 +++
 rtl/mips_cpu_regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_mips_cpu_regfile_wb_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU writeback path.
package mips_cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_CLEAR = 1'b0,
        WB_RUN   = 1'b1
    } wb_state_t;

    // One-hot decode of a register address.
    function automatic logic [NUM_REGS-1:0] reg_decode(input logic [REG_ADDR_W-1:0] addr);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/mips_cpu_regfile_wb_arbiter_chk.sv
// Protocol properties for the writeback arbiter interface.
module mips_cpu_regfile_wb_arbiter_chk #(
    parameter int unsigned NUM_REQ = 3
) (
    input logic               clk,
    input logic               reset_n,
    input logic [NUM_REQ-1:0] req_valid,
    input logic [NUM_REQ-1:0] req_ready,
    input logic               busy,
    input logic [31:0]        pending_mask
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
        (req_ready & ~req_valid) == '0);

    a_pending_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(pending_mask));

    a_no_grant_when_busy: assert property (@(posedge clk) disable iff (!reset_n)
        busy |-> (req_ready == '0));

endmodule

// File: rtl/mips_cpu_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request strictly after the pointer.
module mips_cpu_rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    input  logic             enable,
    output logic [N-1:0]     grant
);

    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_S = SUM_W'(N);

    logic [SUM_W-1:0] sum_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Walk one full lap starting just after the pointer; the first hit wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int k = 1; k <= int'(N); k++) begin
            sum_s = {1'b0, pointer} + SUM_W'(k);
            if (sum_s >= N_S) begin
                idx_s = IDX_W'(sum_s - N_S);
            end else begin
                idx_s = IDX_W'(sum_s);
            end
            grant[idx_s] = grant[idx_s] | (enable & req[idx_s] & ~found_s);
            found_s      = found_s | (enable & req[idx_s]);
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Shares the register file write port between writeback requesters and
// sequences the register file clear after reset.
module mips_cpu_regfile_wb_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_reset,
    output logic                          rf_write_en,
    output logic [REG_ADDR_W-1:0]         rf_write_reg,
    output logic [DATA_W-1:0]             rf_write_data,
    output logic [NUM_REGS-1:0]           pending_mask,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    wb_state_t             state_r;
    wb_state_t             state_nxt_s;
    logic [CNT_W-1:0]      clr_cnt_r;
    logic [CNT_W-1:0]      clr_cnt_nxt_s;
    logic [PTR_W-1:0]      ptr_r;
    logic [NUM_REQ-1:0]    grant_s;
    logic                  grant_any_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic [REG_ADDR_W-1:0] sel_reg_s;
    logic [DATA_W-1:0]     sel_data_s;
    logic                  rf_write_en_r;
    logic [REG_ADDR_W-1:0] rf_write_reg_r;
    logic [DATA_W-1:0]     rf_write_data_r;

    mips_cpu_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .pointer (ptr_r),
        .enable  (state_r == WB_RUN),
        .grant   (grant_s)
    );

    assign grant_any_s = |grant_s;

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            WB_CLEAR: begin
                if (clr_cnt_r == CNT_LAST) begin
                    state_nxt_s   = WB_RUN;
                    clr_cnt_nxt_s = '0;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + CNT_W'(1);
                end
            end
            WB_RUN: begin
                state_nxt_s   = WB_RUN;
                clr_cnt_nxt_s = '0;
            end
            default: begin
                state_nxt_s   = WB_CLEAR;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // AND-OR mux of the granted requester's index, register and data.
    always_comb begin
        grant_idx_s = '0;
        sel_reg_s   = '0;
        sel_data_s  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant_idx_s = grant_idx_s | (PTR_W'(i) & {PTR_W{grant_s[i]}});
            sel_reg_s   = sel_reg_s | (req_reg[i*REG_ADDR_W +: REG_ADDR_W] & {REG_ADDR_W{grant_s[i]}});
            sel_data_s  = sel_data_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

    // Sequencer state, clear counter and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= WB_CLEAR;
            clr_cnt_r <= '0;
            ptr_r     <= PTR_LAST;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            if (grant_any_s) begin
                ptr_r <= grant_idx_s;
            end
        end
    end

    // Output stage; writes to $zero are consumed but never enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_en_r   <= 1'b0;
            rf_write_reg_r  <= '0;
            rf_write_data_r <= '0;
        end else if (grant_any_s) begin
            rf_write_en_r   <= (sel_reg_s != REG_ZERO);
            rf_write_reg_r  <= sel_reg_s;
            rf_write_data_r <= sel_data_s;
        end else begin
            rf_write_en_r   <= 1'b0;
        end
    end

    assign req_ready     = grant_s;
    assign rf_reset      = (state_r == WB_CLEAR);
    assign busy          = (state_r == WB_CLEAR);
    assign rf_write_en   = rf_write_en_r;
    assign rf_write_reg  = rf_write_reg_r;
    assign rf_write_data = rf_write_data_r;
    assign pending_mask  = reg_decode(rf_write_reg_r) & {NUM_REGS{rf_write_en_r}};

endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Directed self-checking bench for the register file writeback arbiter.
module tb_mips_cpu_regfile_wb_arbiter;

    localparam int unsigned NUM_REQ      = 3;
    localparam int unsigned CLEAR_CYCLES = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    req_valid;
    logic [14:0]   req_reg;
    logic [95:0]   req_data;
    logic [2:0]    req_ready;
    logic          rf_reset;
    logic          rf_write_en;
    logic [4:0]    rf_write_reg;
    logic [31:0]   rf_write_data;
    logic [31:0]   pending_mask;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mips_cpu_regfile_wb_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_reset      (rf_reset),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .pending_mask  (pending_mask),
        .busy          (busy)
    );

    mips_cpu_regfile_wb_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .busy         (busy),
        .pending_mask (pending_mask)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_reg[i*5 +: 5]   = r;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic check_out(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
        logic [31:0] exp_mask;
        exp_mask = en ? (32'd1 << r) : 32'd0;
        check_eq({tag, "_en"},   32'(rf_write_en), 32'(en));
        check_eq({tag, "_reg"},  32'(rf_write_reg), 32'(r));
        check_eq({tag, "_data"}, rf_write_data, d);
        check_eq({tag, "_mask"}, pending_mask, exp_mask);
    endtask

    logic [4:0]  regs_t [3];
    logic [31:0] data_t [3];

    initial begin
        int  waited;
        bit  seen;
        regs_t = '{5'd5, 5'd6, 5'd7};
        data_t = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};

        // 1: reset and clear sequence, requesters already waiting
        reset_n   = 1'b0;
        req_valid = 3'b111;
        req_reg   = '0;
        req_data  = '0;
        for (int i = 0; i < 3; i++) set_req(i, regs_t[i], data_t[i]);
        tick();
        tick();
        check_out("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst_rf_reset", 32'(rf_reset), 32'd1);
        check_eq("rst_busy",     32'(busy),     32'd1);
        check_eq("rst_ready",    32'(req_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        check_eq("clr1_rf_reset", 32'(rf_reset), 32'd1);
        check_eq("clr1_busy",     32'(busy),     32'd1);
        check_eq("clr1_ready",    32'(req_ready), 32'd0);
        tick();
        check_eq("run_rf_reset", 32'(rf_reset), 32'd0);
        check_eq("run_busy",     32'(busy),     32'd0);
        check_eq("run_ready0",   32'(req_ready), 32'b001);
        check_eq("run_en0",      32'(rf_write_en), 32'd0);

        // 2: all three valid, round-robin one grant per cycle
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, regs_t[i % 3], data_t[i % 3]);
            check_eq($sformatf("rr%0d_ready", i), 32'(req_ready), 32'd1 << ((i + 1) % 3));
        end
        req_valid = 3'b000;
        #1;
        check_eq("idle_ready", 32'(req_ready), 32'd0);
        tick();
        check_out("idle", 1'b0, 5'd7, data_t[2]);

        // 3: write to $zero is consumed but never enabled
        set_req(1, 5'd0, 32'hDEAD);
        req_valid = 3'b010;
        #1;
        check_eq("zero_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b000;
        check_out("zero", 1'b0, 5'd0, 32'hDEAD);
        #1;
        check_eq("zero_ready_drop", 32'(req_ready), 32'd0);

        // 4: same destination from 0 and 2 with pointer at 2
        set_req(2, 5'd3, 32'd33);
        req_valid = 3'b100;
        #1;
        check_eq("p2_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = 3'b000;
        check_out("p2", 1'b1, 5'd3, 32'd33);
        set_req(0, 5'd9, 32'd1);
        set_req(2, 5'd9, 32'd2);
        req_valid = 3'b101;
        #1;
        check_eq("same_ready0", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b100;
        check_out("same0", 1'b1, 5'd9, 32'd1);
        #1;
        check_eq("same_ready2", 32'(req_ready), 32'b100);
        tick();
        req_valid = 3'b000;
        check_out("same2", 1'b1, 5'd9, 32'd2);
        tick();
        check_out("same_idle", 1'b0, 5'd9, 32'd2);

        // 6: requester 2 must not starve behind 0 and 1
        set_req(0, 5'd5, data_t[0]);
        set_req(1, 5'd6, data_t[1]);
        set_req(2, 5'd12, 32'h0000_1212);
        req_valid = 3'b111;
        #1;
        waited = 0;
        seen   = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (req_ready[2]) begin
                seen = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        check_eq("starve_seen",   32'(seen), 32'd1);
        check_eq("starve_waited", 32'(waited), 32'd2);
        tick();
        req_valid = 3'b000;
        check_out("grant12", 1'b1, 5'd12, 32'h0000_1212);

        // 5: mid-cycle reset discards the in-flight write and reruns clear
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 5'd0, 32'd0);
        check_eq("async_rf_reset", 32'(rf_reset), 32'd1);
        check_eq("async_busy",     32'(busy),     32'd1);
        tick();
        reset_n = 1'b1;
        req_valid = 3'b001;
        tick();
        check_eq("reclr1_rf_reset", 32'(rf_reset), 32'd1);
        check_eq("reclr1_ready",    32'(req_ready), 32'd0);
        tick();
        check_eq("reclr2_rf_reset", 32'(rf_reset), 32'd0);
        check_eq("reclr2_ready",    32'(req_ready), 32'b001);
        check_out("reclr2", 1'b0, 5'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
